rx_control: RTL and testbench



---
 rtl/jesd_rx_pkg.sv | 47 ++++
 rtl/rx_cgs_fsm.sv | 129 ++++++++++++
 rtl/rx_control.sv | 153 +++++++++++++++
 tb/tb_rx_control.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd_rx_pkg.sv
//==============================================================================
// Module      : jesd_rx_pkg
// Description : Shared state encodings and control-character constants for
//               the JESD204B receive link controller.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package jesd_rx_pkg;

    typedef enum logic [1:0] {
        CS_INIT  = 2'd0,
        CS_CHECK = 2'd1,
        CS_DATA  = 2'd2
    } cgs_state_t;

    typedef enum logic [2:0] {
        L_SYNC      = 3'd0,
        L_WAIT_LMFC = 3'd1,
        L_WAIT_ILA  = 3'd2,
        L_ILA       = 3'd3,
        L_DATA      = 3'd4
    } link_state_t;

    localparam logic [7:0] c_K_OCTET = 8'hBC;
    localparam logic [7:0] c_R_OCTET = 8'h1C;
    localparam logic [7:0] c_A_OCTET = 8'h7C;

    localparam logic [2:0] c_HOLD_FRAMES = 3'd5;
    localparam logic [3:0] c_HOLD_CYCLES = 4'd9;

    localparam logic [2:0] c_CGS_K_NEEDED    = 3'd4;
    localparam logic [1:0] c_CGS_ERR_LIMIT   = 2'd3;
    localparam logic [2:0] c_CGS_GOOD_NEEDED = 3'd4;

    // True for an error-free valid control character matching code.
    function automatic logic is_ctrl(input logic       valid,
                                     input logic       is_k,
                                     input logic       err,
                                     input logic [7:0] octet,
                                     input logic [7:0] code);
        return valid && is_k && !err && (octet == code);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rx_cgs_fsm.sv
//==============================================================================
// Module      : rx_cgs_fsm
// Description : Code group synchronization state machine with K, error and
//               good-octet counters plus a saturating resync counter.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rx_cgs_fsm
    import jesd_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_octet_valid,
    input  logic [7:0] i_octet,
    input  logic       i_is_k,
    input  logic       i_disp_err,
    input  logic       i_nit_err,
    input  logic       i_sync_request,
    output cgs_state_t o_state,
    output cgs_state_t o_state_next,
    output logic [7:0] o_resync_cnt
);

    cgs_state_t r_state;
    cgs_state_t w_state_nx;
    logic [2:0] r_kcnt;
    logic [2:0] w_kcnt_nx;
    logic [1:0] r_icnt;
    logic [1:0] w_icnt_nx;
    logic [2:0] r_vcnt;
    logic [2:0] w_vcnt_nx;
    logic [7:0] r_resync;
    logic [7:0] w_resync_nx;
    logic       w_err;
    logic       w_kchar;

    assign w_err   = i_octet_valid && (i_disp_err || i_nit_err);
    assign w_kchar = is_ctrl(i_octet_valid, i_is_k, w_err, i_octet, c_K_OCTET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= CS_INIT;
            r_kcnt   <= 3'd0;
            r_icnt   <= 2'd0;
            r_vcnt   <= 3'd0;
            r_resync <= 8'd0;
        end else begin
            r_state  <= w_state_nx;
            r_kcnt   <= w_kcnt_nx;
            r_icnt   <= w_icnt_nx;
            r_vcnt   <= w_vcnt_nx;
            r_resync <= w_resync_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_kcnt_nx   = r_kcnt;
        w_icnt_nx   = r_icnt;
        w_vcnt_nx   = r_vcnt;
        w_resync_nx = r_resync;
        if (i_sync_request) begin
            w_state_nx = CS_INIT;
            w_kcnt_nx  = 3'd0;
            w_icnt_nx  = 2'd0;
            w_vcnt_nx  = 3'd0;
        end else if (i_octet_valid) begin
            case (r_state)
                CS_INIT: begin
                    if (w_kchar) begin
                        if (r_kcnt + 3'd1 == c_CGS_K_NEEDED) begin
                            w_state_nx = CS_DATA;
                            w_kcnt_nx  = 3'd0;
                        end else begin
                            w_kcnt_nx = r_kcnt + 3'd1;
                        end
                    end else begin
                        w_kcnt_nx = 3'd0;
                    end
                end
                CS_DATA: begin
                    if (w_err) begin
                        w_state_nx = CS_CHECK;
                        w_icnt_nx  = 2'd1;
                        w_vcnt_nx  = 3'd0;
                    end
                end
                CS_CHECK: begin
                    if (w_err) begin
                        w_vcnt_nx = 3'd0;
                        if (r_icnt + 2'd1 == c_CGS_ERR_LIMIT) begin
                            w_state_nx = CS_INIT;
                            w_icnt_nx  = 2'd0;
                            w_kcnt_nx  = 3'd0;
                            if (r_resync != 8'hFF) begin
                                w_resync_nx = r_resync + 8'd1;
                            end
                        end else begin
                            w_icnt_nx = r_icnt + 2'd1;
                        end
                    end else if (r_vcnt + 3'd1 == c_CGS_GOOD_NEEDED) begin
                        // A full run of good octets forgives one error.
                        w_vcnt_nx = 3'd0;
                        w_icnt_nx = r_icnt - 2'd1;
                        if (r_icnt == 2'd1) begin
                            w_state_nx = CS_DATA;
                        end
                    end else begin
                        w_vcnt_nx = r_vcnt + 3'd1;
                    end
                end
                default: begin
                    w_state_nx = CS_INIT;
                    w_kcnt_nx  = 3'd0;
                    w_icnt_nx  = 2'd0;
                    w_vcnt_nx  = 3'd0;
                end
            endcase
        end
    end

    assign o_state      = r_state;
    assign o_state_next = w_state_nx;
    assign o_resync_cnt = r_resync;

endmodule

`default_nettype wire

// File: rtl/rx_control.sv
//==============================================================================
// Module      : rx_control
// Description : JESD204B receive link controller: CGS, SYNC~ hold/release on
//               LMFC, ILA tracking and user-data phase indication.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module rx_control
    import jesd_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_clk,
    input  logic       lmfc_clk,
    input  logic       i_octet_valid,
    input  logic [7:0] i_octet,
    input  logic       i_is_k,
    input  logic       i_disp_err,
    input  logic       i_nit_err,
    input  logic       i_sync_request,
    input  logic [7:0] i_ila_multiframe_length,
    output logic       o_sync_n,
    output logic [1:0] o_cgs_state,
    output logic       o_ila_start,
    output logic       o_data_phase,
    output logic [7:0] o_resync_cnt
);

    cgs_state_t  w_cgs_state;
    cgs_state_t  w_cgs_next;
    link_state_t r_link;
    link_state_t w_link_nx;
    logic [2:0]  r_hfr;
    logic [2:0]  w_hfr_nx;
    logic [3:0]  r_hcyc;
    logic [3:0]  w_hcyc_nx;
    logic [8:0]  r_acnt;
    logic [8:0]  w_acnt_nx;
    logic        w_ila_start_nx;
    logic        r_sync_n;
    logic        r_ila_start;
    logic        r_data_phase;
    logic        w_err;
    logic        w_is_r;
    logic        w_is_a;
    logic        w_resync;

    rx_cgs_fsm u_cgs (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_octet_valid  (i_octet_valid),
        .i_octet        (i_octet),
        .i_is_k         (i_is_k),
        .i_disp_err     (i_disp_err),
        .i_nit_err      (i_nit_err),
        .i_sync_request (i_sync_request),
        .o_state        (w_cgs_state),
        .o_state_next   (w_cgs_next),
        .o_resync_cnt   (o_resync_cnt)
    );

    assign w_err    = i_disp_err || i_nit_err;
    assign w_is_r   = is_ctrl(i_octet_valid, i_is_k, w_err, i_octet, c_R_OCTET);
    assign w_is_a   = is_ctrl(i_octet_valid, i_is_k, w_err, i_octet, c_A_OCTET);
    // Looking at the CGS next state keeps SYNC~ in step with the CGS register.
    assign w_resync = i_sync_request || (w_cgs_next == CS_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_link       <= L_SYNC;
            r_hfr        <= 3'd0;
            r_hcyc       <= 4'd0;
            r_acnt       <= 9'd0;
            r_sync_n     <= 1'b0;
            r_ila_start  <= 1'b0;
            r_data_phase <= 1'b0;
        end else begin
            r_link       <= w_link_nx;
            r_hfr        <= w_hfr_nx;
            r_hcyc       <= w_hcyc_nx;
            r_acnt       <= w_acnt_nx;
            r_sync_n     <= (w_link_nx == L_WAIT_ILA) || (w_link_nx == L_ILA) ||
                            (w_link_nx == L_DATA);
            r_ila_start  <= w_ila_start_nx;
            r_data_phase <= (w_link_nx == L_DATA);
        end
    end

    always_comb begin
        w_link_nx      = r_link;
        w_hfr_nx       = r_hfr;
        w_hcyc_nx      = r_hcyc;
        w_acnt_nx      = r_acnt;
        w_ila_start_nx = 1'b0;
        if (w_resync) begin
            w_link_nx = L_SYNC;
            w_hfr_nx  = 3'd0;
            w_hcyc_nx = 4'd0;
            w_acnt_nx = 9'd0;
        end else begin
            case (r_link)
                L_SYNC: begin
                    if (frame_clk && (r_hfr != c_HOLD_FRAMES)) begin
                        w_hfr_nx = r_hfr + 3'd1;
                    end
                    if (r_hcyc != c_HOLD_CYCLES) begin
                        w_hcyc_nx = r_hcyc + 4'd1;
                    end
                    if ((w_cgs_next == CS_DATA) && (r_hfr == c_HOLD_FRAMES) &&
                        (r_hcyc == c_HOLD_CYCLES)) begin
                        w_link_nx = L_WAIT_LMFC;
                    end
                end
                L_WAIT_LMFC: begin
                    if (lmfc_clk) begin
                        w_link_nx = L_WAIT_ILA;
                    end
                end
                L_WAIT_ILA: begin
                    if (w_is_r) begin
                        w_link_nx      = L_ILA;
                        w_ila_start_nx = 1'b1;
                        w_acnt_nx      = 9'd0;
                    end
                end
                L_ILA: begin
                    if (w_is_a) begin
                        w_acnt_nx = r_acnt + 9'd1;
                        // The incremented count equals length+1 exactly here.
                        if (r_acnt == {1'b0, i_ila_multiframe_length}) begin
                            w_link_nx = L_DATA;
                        end
                    end
                end
                L_DATA: begin
                    w_link_nx = L_DATA;
                end
                default: begin
                    w_link_nx = L_SYNC;
                end
            endcase
        end
    end

    assign o_sync_n     = r_sync_n;
    assign o_cgs_state  = w_cgs_state;
    assign o_ila_start  = r_ila_start;
    assign o_data_phase = r_data_phase;

endmodule

`default_nettype wire

// File: tb/tb_rx_control.sv
//==============================================================================
// Module      : tb_rx_control
// Description : Directed self-checking bench for rx_control.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_rx_control;

    logic       clk;
    logic       rst_n;
    logic       frame_clk;
    logic       lmfc_clk;
    logic       octet_valid;
    logic [7:0] octet;
    logic       is_k;
    logic       disp_err;
    logic       nit_err;
    logic       sync_request;
    logic [7:0] ila_len;
    logic       sync_n;
    logic [1:0] cgs_state;
    logic       ila_start;
    logic       data_phase;
    logic [7:0] resync_cnt;

    int n_vec;
    int n_err;

    rx_control dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .frame_clk               (frame_clk),
        .lmfc_clk                (lmfc_clk),
        .i_octet_valid           (octet_valid),
        .i_octet                 (octet),
        .i_is_k                  (is_k),
        .i_disp_err              (disp_err),
        .i_nit_err               (nit_err),
        .i_sync_request          (sync_request),
        .i_ila_multiframe_length (ila_len),
        .o_sync_n                (sync_n),
        .o_cgs_state             (cgs_state),
        .o_ila_start             (ila_start),
        .o_data_phase            (data_phase),
        .o_resync_cnt            (resync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_oct(input logic [7:0] o, input logic k, input logic d, input logic n);
        octet_valid = 1'b1;
        octet       = o;
        is_k        = k;
        disp_err    = d;
        nit_err     = n;
        tick();
        octet_valid = 1'b0;
        octet       = 8'h00;
        is_k        = 1'b0;
        disp_err    = 1'b0;
        nit_err     = 1'b0;
    endtask

    task automatic send_idle(input logic f, input logic l);
        frame_clk = f;
        lmfc_clk  = l;
        tick();
        frame_clk = 1'b0;
        lmfc_clk  = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Four /K/, hold for 5 frames over 10 cycles, settle, then one LMFC strobe.
    task automatic link_up;
        for (int i = 0; i < 4; i++) send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) send_idle((i % 2) == 0, 1'b0);
        for (int i = 0; i < 3; i++) send_idle(1'b0, 1'b0);
        send_idle(1'b0, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL reset_sync_n: got %0d expected 0", sync_n); end
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL reset_cgs: got %0d expected 0", cgs_state); end
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL reset_ila_start: got %0d expected 0", ila_start); end
        n_vec++; if (data_phase !== 1'b0) begin n_err++; $display("FAIL reset_data_phase: got %0d expected 0", data_phase); end
        n_vec++; if (resync_cnt !== 8'd0) begin n_err++; $display("FAIL reset_resync: got %0d expected 0", resync_cnt); end
        do_reset();
    endtask

    task automatic test_kcnt_reset;
        for (int i = 0; i < 3; i++) send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        send_oct(8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL kcnt_broken: got %0d expected 0", cgs_state); end
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd2) begin n_err++; $display("FAIL kcnt_fourth: got %0d expected 2", cgs_state); end
    endtask

    task automatic test_gaps;
        do_reset();
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        send_idle(1'b0, 1'b0);
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        send_idle(1'b0, 1'b0);
        send_idle(1'b0, 1'b0);
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL gaps_third_k: got %0d expected 0", cgs_state); end
        send_idle(1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL gaps_idle: got %0d expected 0", cgs_state); end
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd2) begin n_err++; $display("FAIL gaps_fourth_k: got %0d expected 2", cgs_state); end
    endtask

    task automatic test_cgs_lock;
        do_reset();
        for (int i = 0; i < 4; i++) send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd2) begin n_err++; $display("FAIL lock_cgs: got %0d expected 2", cgs_state); end
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL lock_sync_n_early: got %0d expected 0", sync_n); end
        send_idle(1'b0, 1'b1);
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL lock_lmfc_ignored: got %0d expected 0", sync_n); end
        for (int i = 0; i < 10; i++) send_idle((i % 2) == 0, 1'b0);
        for (int i = 0; i < 3; i++) send_idle(1'b0, 1'b0);
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL lock_hold_no_lmfc: got %0d expected 0", sync_n); end
        send_idle(1'b0, 1'b1);
        n_vec++; if (sync_n !== 1'b1) begin n_err++; $display("FAIL lock_release: got %0d expected 1", sync_n); end
    endtask

    task automatic test_ila;
        ila_len = 8'd3;
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL ila_k_no_start: got %0d expected 0", ila_start); end
        send_oct(8'h1C, 1'b1, 1'b0, 1'b0);
        n_vec++; if (ila_start !== 1'b1) begin n_err++; $display("FAIL ila_start_pulse: got %0d expected 1", ila_start); end
        send_oct(8'h00, 1'b0, 1'b0, 1'b0);
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL ila_start_width: got %0d expected 0", ila_start); end
        for (int i = 0; i < 3; i++) begin
            send_oct(8'h7C, 1'b1, 1'b0, 1'b0);
            send_oct(8'h1C, 1'b1, 1'b0, 1'b0);
        end
        n_vec++; if (data_phase !== 1'b0) begin n_err++; $display("FAIL ila_third_a: got %0d expected 0", data_phase); end
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL ila_r_in_ila: got %0d expected 0", ila_start); end
        send_oct(8'h7C, 1'b1, 1'b0, 1'b0);
        n_vec++; if (data_phase !== 1'b1) begin n_err++; $display("FAIL ila_fourth_a: got %0d expected 1", data_phase); end
        n_vec++; if (sync_n !== 1'b1) begin n_err++; $display("FAIL ila_sync_n_data: got %0d expected 1", sync_n); end
    endtask

    task automatic test_sync_request;
        sync_request = 1'b1;
        send_oct(8'hBC, 1'b1, 1'b0, 1'b0);
        sync_request = 1'b0;
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL sreq_sync_n: got %0d expected 0", sync_n); end
        n_vec++; if (data_phase !== 1'b0) begin n_err++; $display("FAIL sreq_data_phase: got %0d expected 0", data_phase); end
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL sreq_cgs: got %0d expected 0", cgs_state); end
        n_vec++; if (resync_cnt !== 8'd0) begin n_err++; $display("FAIL sreq_resync: got %0d expected 0", resync_cnt); end
        link_up();
        n_vec++; if (sync_n !== 1'b1) begin n_err++; $display("FAIL sreq_relink: got %0d expected 1", sync_n); end
        sync_request = 1'b1;
        send_oct(8'h1C, 1'b1, 1'b0, 1'b0);
        sync_request = 1'b0;
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL sreq_r_collide: got %0d expected 0", ila_start); end
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL sreq_r_sync_n: got %0d expected 0", sync_n); end
    endtask

    task automatic test_check_recover;
        link_up();
        send_oct(8'h55, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cgs_state !== 2'd1) begin n_err++; $display("FAIL chk_enter: got %0d expected 1", cgs_state); end
        n_vec++; if (sync_n !== 1'b1) begin n_err++; $display("FAIL chk_sync_n_held: got %0d expected 1", sync_n); end
        for (int i = 0; i < 3; i++) send_oct(8'h55, 1'b0, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd1) begin n_err++; $display("FAIL chk_three_good: got %0d expected 1", cgs_state); end
        send_oct(8'h55, 1'b0, 1'b0, 1'b0);
        n_vec++; if (cgs_state !== 2'd2) begin n_err++; $display("FAIL chk_recover: got %0d expected 2", cgs_state); end
        send_oct(8'h55, 1'b0, 1'b1, 1'b0);
        send_oct(8'h55, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cgs_state !== 2'd1) begin n_err++; $display("FAIL chk_two_err: got %0d expected 1", cgs_state); end
        send_oct(8'h55, 1'b0, 1'b0, 1'b1);
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL chk_to_init: got %0d expected 0", cgs_state); end
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL chk_sync_n_drop: got %0d expected 0", sync_n); end
        n_vec++; if (resync_cnt !== 8'd1) begin n_err++; $display("FAIL chk_resync_cnt: got %0d expected 1", resync_cnt); end
    endtask

    task automatic test_async_reset;
        link_up();
        send_oct(8'h1C, 1'b1, 1'b0, 1'b0);
        send_oct(8'h7C, 1'b1, 1'b0, 1'b0);
        n_vec++; if (sync_n !== 1'b1) begin n_err++; $display("FAIL arst_pre_sync_n: got %0d expected 1", sync_n); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (sync_n !== 1'b0) begin n_err++; $display("FAIL arst_sync_n: got %0d expected 0", sync_n); end
        n_vec++; if (cgs_state !== 2'd0) begin n_err++; $display("FAIL arst_cgs: got %0d expected 0", cgs_state); end
        n_vec++; if (ila_start !== 1'b0) begin n_err++; $display("FAIL arst_ila_start: got %0d expected 0", ila_start); end
        n_vec++; if (data_phase !== 1'b0) begin n_err++; $display("FAIL arst_data_phase: got %0d expected 0", data_phase); end
        n_vec++; if (resync_cnt !== 8'd0) begin n_err++; $display("FAIL arst_resync: got %0d expected 0", resync_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        frame_clk    = 1'b0;
        lmfc_clk     = 1'b0;
        octet_valid  = 1'b0;
        octet        = 8'h00;
        is_k         = 1'b0;
        disp_err     = 1'b0;
        nit_err      = 1'b0;
        sync_request = 1'b0;
        ila_len      = 8'd3;

        test_reset();
        test_kcnt_reset();
        test_gaps();
        test_cgs_lock();
        test_ila();
        test_sync_request();
        test_check_recover();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
